// File: rtl/pipeline_pkg.sv
// Shared types and widths for the ID/EX stage: ALU opcodes, operand selects,
// forwarding source tags and the registered ID field bundle.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_AND  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    typedef enum logic {
        OPA_RS1 = 1'b0,
        OPA_PC  = 1'b1
    } opa_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Data-path fields that a bubble leaves untouched.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   rs1_addr;
        logic [RA_W-1:0]   rs2_addr;
        logic [RA_W-1:0]   rd_addr;
        opa_sel_e          opa_sel;
        opb_sel_e          opb_sel;
    } ex_data_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle around the ID/EX stage: decoded ID fields, MEM/WB forwarding
// sources and the EX-side outputs. The stage uses the slave modport.
interface id_ex_stage_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              flush_i;
    logic              id_valid_i;
    logic [DATA_W-1:0] id_pc_i;
    logic [RA_W-1:0]   id_rs1_addr_i;
    logic [RA_W-1:0]   id_rs2_addr_i;
    logic [DATA_W-1:0] id_rs1_data_i;
    logic [DATA_W-1:0] id_rs2_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [RA_W-1:0]   id_rd_addr_i;
    logic              id_rd_wren_i;
    logic [3:0]        id_alu_op_i;
    logic              id_opa_sel_i;
    logic              id_opb_sel_i;
    logic              id_mem_rden_i;
    logic              id_mem_wren_i;
    logic [RA_W-1:0]   mem_rd_addr_i;
    logic              mem_rd_wren_i;
    logic [DATA_W-1:0] mem_alu_data_i;
    logic [RA_W-1:0]   wb_rd_addr_i;
    logic              wb_rd_wren_i;
    logic [DATA_W-1:0] wb_data_i;

    logic [DATA_W-1:0] operand_a_o;
    logic [DATA_W-1:0] operand_b_o;
    logic [3:0]        alu_op_o;
    logic              ex_valid_o;
    logic [RA_W-1:0]   ex_rd_addr_o;
    logic              ex_rd_wren_o;
    logic              ex_mem_rden_o;
    logic              ex_mem_wren_o;
    logic [DATA_W-1:0] ex_store_data_o;
    logic [DATA_W-1:0] ex_pc_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rd_addr_i, id_rd_wren_i,
               id_alu_op_i, id_opa_sel_i, id_opb_sel_i, id_mem_rden_i, id_mem_wren_i,
               mem_rd_addr_i, mem_rd_wren_i, mem_alu_data_i,
               wb_rd_addr_i, wb_rd_wren_i, wb_data_i,
        input  operand_a_o, operand_b_o, alu_op_o, ex_valid_o, ex_rd_addr_o,
               ex_rd_wren_o, ex_mem_rden_o, ex_mem_wren_o, ex_store_data_o,
               ex_pc_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rd_addr_i, id_rd_wren_i,
               id_alu_op_i, id_opa_sel_i, id_opb_sel_i, id_mem_rden_i, id_mem_wren_i,
               mem_rd_addr_i, mem_rd_wren_i, mem_alu_data_i,
               wb_rd_addr_i, wb_rd_wren_i, wb_data_i,
        output operand_a_o, operand_b_o, alu_op_o, ex_valid_o, ex_rd_addr_o,
               ex_rd_wren_o, ex_mem_rden_o, ex_mem_wren_o, ex_store_data_o,
               ex_pc_o, stall_o, stall_cnt_o
    );

endinterface

// File: rtl/fwd_unit.sv
// Per-register forwarding mux: MEM result beats WB result beats regfile data;
// x0 is never forwarded and always reads zero.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic [RA_W-1:0]   rs_addr_i,
    input  logic [RA_W-1:0]   mem_rd_addr_i,
    input  logic              mem_rd_wren_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [RA_W-1:0]   wb_rd_addr_i,
    input  logic              wb_rd_wren_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DATA_W-1:0] fwd_data_o,
    output fwd_sel_e          fwd_sel_o
);
    logic rs_nz;

    assign rs_nz = (rs_addr_i != '0);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (rs_nz && mem_rd_wren_i && (mem_rd_addr_i == rs_addr_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (rs_nz && wb_rd_wren_i && (wb_rd_addr_i == rs_addr_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

    always_comb begin
        case (fwd_sel_o)
            FWD_MEM: fwd_data_o = mem_data_i;
            FWD_WB:  fwd_data_o = wb_data_i;
            default: fwd_data_o = rs_nz ? rf_data_i : '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding and select,
// load-use hazard detection with bubble insertion, saturating stall counter.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic          clk_i,
    input logic          rst_ni,
    id_ex_stage_if.slave io
);
    ex_data_t          ex_q, ex_d;
    logic              valid_q, valid_d;
    logic              rd_wren_q, rd_wren_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    alu_op_e           alu_op_q, alu_op_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] fwd_rs1, fwd_rs2;
    fwd_sel_e          fwd_sel_rs1, fwd_sel_rs2;
    logic              hz, stall, bubble, capture_en;
    logic              unused_fwd_sel;

    fwd_unit u_fwd_rs1 (
        .rs_addr_i     (ex_q.rs1_addr),
        .mem_rd_addr_i (io.mem_rd_addr_i),
        .mem_rd_wren_i (io.mem_rd_wren_i),
        .mem_data_i    (io.mem_alu_data_i),
        .wb_rd_addr_i  (io.wb_rd_addr_i),
        .wb_rd_wren_i  (io.wb_rd_wren_i),
        .wb_data_i     (io.wb_data_i),
        .rf_data_i     (ex_q.rs1_data),
        .fwd_data_o    (fwd_rs1),
        .fwd_sel_o     (fwd_sel_rs1)
    );

    fwd_unit u_fwd_rs2 (
        .rs_addr_i     (ex_q.rs2_addr),
        .mem_rd_addr_i (io.mem_rd_addr_i),
        .mem_rd_wren_i (io.mem_rd_wren_i),
        .mem_data_i    (io.mem_alu_data_i),
        .wb_rd_addr_i  (io.wb_rd_addr_i),
        .wb_rd_wren_i  (io.wb_rd_wren_i),
        .wb_data_i     (io.wb_data_i),
        .rf_data_i     (ex_q.rs2_data),
        .fwd_data_o    (fwd_rs2),
        .fwd_sel_o     (fwd_sel_rs2)
    );

    assign unused_fwd_sel = ^{fwd_sel_rs1, fwd_sel_rs2};

    // Both rs fields are compared, even when operand_b comes from the immediate.
    assign hz = valid_q & mem_rden_q & (rd_addr_nz(ex_q.rd_addr))
              & io.id_valid_i
              & ((io.id_rs1_addr_i == ex_q.rd_addr) | (io.id_rs2_addr_i == ex_q.rd_addr));
    assign stall      = hz & ~io.flush_i;
    assign bubble     = io.flush_i | hz;
    assign capture_en = ~bubble & io.id_valid_i;

    function automatic logic rd_addr_nz(input logic [RA_W-1:0] a);
        return a != '0;
    endfunction

    always_comb begin
        ex_d        = ex_q;
        valid_d     = capture_en;
        rd_wren_d   = capture_en & io.id_rd_wren_i;
        mem_rden_d  = capture_en & io.id_mem_rden_i;
        mem_wren_d  = capture_en & io.id_mem_wren_i;
        alu_op_d    = ALU_ADD;
        stall_cnt_d = stall_cnt_q;
        if (!bubble) begin
            alu_op_d      = alu_op_e'(io.id_alu_op_i);
            ex_d.pc       = io.id_pc_i;
            ex_d.rs1_data = io.id_rs1_data_i;
            ex_d.rs2_data = io.id_rs2_data_i;
            ex_d.imm      = io.id_imm_i;
            ex_d.rs1_addr = io.id_rs1_addr_i;
            ex_d.rs2_addr = io.id_rs2_addr_i;
            ex_d.rd_addr  = io.id_rd_addr_i;
            ex_d.opa_sel  = opa_sel_e'(io.id_opa_sel_i);
            ex_d.opb_sel  = opb_sel_e'(io.id_opb_sel_i);
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q        <= '0;
            valid_q     <= 1'b0;
            rd_wren_q   <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            alu_op_q    <= ALU_ADD;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            valid_q     <= valid_d;
            rd_wren_q   <= rd_wren_d;
            mem_rden_q  <= mem_rden_d;
            mem_wren_q  <= mem_wren_d;
            alu_op_q    <= alu_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io.operand_a_o     = (ex_q.opa_sel == OPA_PC)  ? ex_q.pc  : fwd_rs1;
    assign io.operand_b_o     = (ex_q.opb_sel == OPB_IMM) ? ex_q.imm : fwd_rs2;
    assign io.alu_op_o        = alu_op_q;
    assign io.ex_valid_o      = valid_q;
    assign io.ex_rd_addr_o    = ex_q.rd_addr;
    assign io.ex_rd_wren_o    = rd_wren_q;
    assign io.ex_mem_rden_o   = mem_rden_q;
    assign io.ex_mem_wren_o   = mem_wren_q;
    assign io.ex_store_data_o = fwd_rs2;
    assign io.ex_pc_o         = ex_q.pc;
    assign io.stall_o         = stall;
    assign io.stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic, all
// checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_stage_if #(.CNT_W(CW)) bus ();

    id_ex_stage #(.CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Model of the instruction sitting in EX.
    typedef struct {
        bit          v;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        bit          wren, rden, mwren, opa, opb;
        logic [3:0]  op;
    } ex_t;

    ex_t         m;
    int          cnt_m;
    bit          last_hz, last_stall;
    logic [3:0]  ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural value of register r as EX should see it right now.
    function automatic logic [31:0] see(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (bus.mem_rd_wren_i && bus.mem_rd_addr_i == r) return bus.mem_alu_data_i;
        if (bus.wb_rd_wren_i && bus.wb_rd_addr_i == r) return bus.wb_data_i;
        return rf;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        cnt_m = 0;
    endtask

    task automatic clear_inputs();
        bus.flush_i = 0;        bus.id_valid_i = 0;     bus.id_pc_i = '0;
        bus.id_rs1_addr_i = '0; bus.id_rs2_addr_i = '0; bus.id_rs1_data_i = '0;
        bus.id_rs2_data_i = '0; bus.id_imm_i = '0;      bus.id_rd_addr_i = '0;
        bus.id_rd_wren_i = 0;   bus.id_alu_op_i = '0;   bus.id_opa_sel_i = 0;
        bus.id_opb_sel_i = 0;   bus.id_mem_rden_i = 0;  bus.id_mem_wren_i = 0;
        bus.mem_rd_addr_i = '0; bus.mem_rd_wren_i = 0;  bus.mem_alu_data_i = '0;
        bus.wb_rd_addr_i = '0;  bus.wb_rd_wren_i = 0;   bus.wb_data_i = '0;
    endtask

    task automatic rand_inputs();
        bus.flush_i        = ($urandom_range(0, 9) == 0);
        bus.id_valid_i     = ($urandom_range(0, 4) != 0);
        bus.id_pc_i        = $urandom;
        bus.id_rs1_addr_i  = 5'($urandom_range(0, 7));
        bus.id_rs2_addr_i  = 5'($urandom_range(0, 7));
        bus.id_rs1_data_i  = $urandom;
        bus.id_rs2_data_i  = $urandom;
        bus.id_imm_i       = $urandom;
        bus.id_rd_addr_i   = 5'($urandom_range(0, 7));
        bus.id_rd_wren_i   = 1'($urandom_range(0, 1));
        bus.id_alu_op_i    = ops[$urandom_range(0, 10)];
        bus.id_opa_sel_i   = 1'($urandom_range(0, 1));
        bus.id_opb_sel_i   = 1'($urandom_range(0, 1));
        bus.id_mem_rden_i  = ($urandom_range(0, 1) == 0);
        bus.id_mem_wren_i  = !bus.id_mem_rden_i && ($urandom_range(0, 2) == 0);
        bus.mem_rd_addr_i  = 5'($urandom_range(0, 7));
        bus.mem_rd_wren_i  = 1'($urandom_range(0, 1));
        bus.mem_alu_data_i = $urandom;
        bus.wb_rd_addr_i   = 5'($urandom_range(0, 7));
        bus.wb_rd_wren_i   = 1'($urandom_range(0, 1));
        bus.wb_data_i      = $urandom;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [4:0] rd, input logic wren,
                          input logic [3:0] op, input logic rden);
        bus.id_valid_i = 1; bus.id_rs1_addr_i = rs1; bus.id_rs2_addr_i = rs2;
        bus.id_rs1_data_i = d1; bus.id_rs2_data_i = d2; bus.id_rd_addr_i = rd;
        bus.id_rd_wren_i = wren; bus.id_alu_op_i = op; bus.id_mem_rden_i = rden;
        bus.id_mem_wren_i = 0; bus.id_opa_sel_i = 0; bus.id_opb_sel_i = 0;
    endtask

    task automatic settle_check();
        #1;
        last_hz = m.v && m.rden && (m.rd != 0) && bus.id_valid_i
                  && (bus.id_rs1_addr_i == m.rd || bus.id_rs2_addr_i == m.rd);
        last_stall = last_hz && !bus.flush_i;
        check_eq("stall", 64'(bus.stall_o), 64'(last_stall));
        check_eq("stall_cnt", 64'(bus.stall_cnt_o), 64'(cnt_m));
        check_eq("ex_valid", 64'(bus.ex_valid_o), 64'(m.v));
        check_eq("alu_op", 64'(bus.alu_op_o), 64'(m.op));
        check_eq("rd_wren", 64'(bus.ex_rd_wren_o), 64'(m.wren));
        check_eq("mem_rden", 64'(bus.ex_mem_rden_o), 64'(m.rden));
        check_eq("mem_wren", 64'(bus.ex_mem_wren_o), 64'(m.mwren));
        if (m.v) begin
            check_eq("operand_a", 64'(bus.operand_a_o), 64'(m.opa ? m.pc : see(m.rs1, m.rs1d)));
            check_eq("operand_b", 64'(bus.operand_b_o), 64'(m.opb ? m.imm : see(m.rs2, m.rs2d)));
            check_eq("store_data", 64'(bus.ex_store_data_o), 64'(see(m.rs2, m.rs2d)));
            check_eq("ex_pc", 64'(bus.ex_pc_o), 64'(m.pc));
            check_eq("ex_rd_addr", 64'(bus.ex_rd_addr_o), 64'(m.rd));
        end
    endtask

    // Edge: a flushed or hazarded slot becomes a no-op, otherwise ID moves into EX.
    task automatic advance();
        @(posedge clk);
        if (bus.flush_i || last_hz) begin
            m.v = 0; m.wren = 0; m.rden = 0; m.mwren = 0; m.op = 4'h0;
        end else begin
            m.v     = bus.id_valid_i;
            m.pc    = bus.id_pc_i;
            m.rs1   = bus.id_rs1_addr_i;   m.rs2  = bus.id_rs2_addr_i;
            m.rs1d  = bus.id_rs1_data_i;   m.rs2d = bus.id_rs2_data_i;
            m.imm   = bus.id_imm_i;        m.rd   = bus.id_rd_addr_i;
            m.wren  = bus.id_valid_i && bus.id_rd_wren_i;
            m.rden  = bus.id_valid_i && bus.id_mem_rden_i;
            m.mwren = bus.id_valid_i && bus.id_mem_wren_i;
            m.opa   = bus.id_opa_sel_i;    m.opb  = bus.id_opb_sel_i;
            m.op    = bus.id_alu_op_i;
        end
        if (last_stall && cnt_m < CNTMAX) cnt_m++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Plain ADD x1 + x2
        set_id(5'd1, 5'd2, 32'd10, 32'd5, 5'd3, 1, 4'h0, 0);
        settle_check(); advance();
        bus.id_valid_i = 0;
        settle_check();
        check_eq("add_opa", 64'(bus.operand_a_o), 64'd10);
        check_eq("add_opb", 64'(bus.operand_b_o), 64'd5);
        check_eq("add_valid", 64'(bus.ex_valid_o), 64'd1);
        advance();

        // MEM beats WB beats regfile
        set_id(5'd5, 5'd0, 32'h1, 32'h0, 5'd4, 1, 4'h0, 0);
        settle_check(); advance();
        bus.id_valid_i = 0;
        bus.mem_rd_addr_i = 5'd5; bus.mem_rd_wren_i = 1; bus.mem_alu_data_i = 32'h15;
        bus.wb_rd_addr_i  = 5'd5; bus.wb_rd_wren_i  = 1; bus.wb_data_i      = 32'h99;
        settle_check();
        check_eq("fwd_mem", 64'(bus.operand_a_o), 64'h15);
        bus.mem_rd_wren_i = 0;
        settle_check();
        check_eq("fwd_wb", 64'(bus.operand_a_o), 64'h99);
        advance();

        // x0 is never forwarded
        bus.wb_rd_wren_i = 0;
        set_id(5'd0, 5'd0, 32'h1234, 32'h0, 5'd4, 1, 4'h0, 0);
        settle_check(); advance();
        bus.id_valid_i = 0;
        bus.mem_rd_addr_i = 5'd0; bus.mem_rd_wren_i = 1; bus.mem_alu_data_i = 32'hFFFF;
        settle_check();
        check_eq("x0_opa", 64'(bus.operand_a_o), 64'h0);
        advance();
        bus.mem_rd_wren_i = 0;

        // Load-use: LW x7 then ADD using x7 as rs2
        set_id(5'd1, 5'd0, 32'h0, 32'h0, 5'd7, 1, 4'h0, 1);
        settle_check(); advance();
        set_id(5'd1, 5'd7, 32'h3, 32'h5555, 5'd8, 1, 4'h0, 0);
        settle_check();
        check_eq("lu_stall", 64'(bus.stall_o), 64'd1);
        advance();
        bus.wb_rd_addr_i = 5'd7; bus.wb_rd_wren_i = 1; bus.wb_data_i = 32'hABCD;
        settle_check();
        check_eq("lu_stall_drop", 64'(bus.stall_o), 64'd0);
        check_eq("lu_bubble", 64'(bus.ex_valid_o), 64'd0);
        check_eq("lu_cnt", 64'(bus.stall_cnt_o), 64'd1);
        advance();
        bus.id_valid_i = 0;
        settle_check();
        check_eq("lu_opb_wb", 64'(bus.operand_b_o), 64'hABCD);
        check_eq("lu_issue", 64'(bus.ex_valid_o), 64'd1);
        advance();
        bus.wb_rd_wren_i = 0;

        // Flush and hazard together: no stall, bubble, counter untouched
        set_id(5'd1, 5'd0, 32'h0, 32'h0, 5'd7, 1, 4'h0, 1);
        settle_check(); advance();
        set_id(5'd7, 5'd2, 32'h0, 32'h0, 5'd9, 1, 4'h0, 0);
        bus.flush_i = 1;
        settle_check();
        check_eq("fl_stall", 64'(bus.stall_o), 64'd0);
        advance();
        bus.flush_i = 0;
        set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 1, 4'hF, 0);
        bus.id_opb_sel_i = 1; bus.id_imm_i = 32'h12345000;
        settle_check();
        check_eq("fl_bubble", 64'(bus.ex_valid_o), 64'd0);
        check_eq("fl_cnt", 64'(bus.stall_cnt_o), 64'd1);
        advance();
        bus.id_valid_i = 0;
        settle_check();
        check_eq("lui_opb", 64'(bus.operand_b_o), 64'h12345000);
        check_eq("lui_op", 64'(bus.alu_op_o), 64'hF);

        // Asynchronous reset between edges takes effect immediately
        rst_n = 0;
        #1;
        check_eq("rst_valid", 64'(bus.ex_valid_o), 64'd0);
        check_eq("rst_alu_op", 64'(bus.alu_op_o), 64'h0);
        check_eq("rst_opa", 64'(bus.operand_a_o), 64'h0);
        check_eq("rst_opb", 64'(bus.operand_b_o), 64'h0);
        check_eq("rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
        check_eq("rst_rden", 64'(bus.ex_mem_rden_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic, long enough to saturate the small counter
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            settle_check();
            advance();
        end
        check_eq("cnt_saturated", 64'(bus.stall_cnt_o), 64'(CNTMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
